// File: rtl/rst_sequencer.sv
// rst_sequencer: root reset conditioner for one clock domain.
// Takes the board-level asynchronous active-low reset `rst`, asserts `rst_out`
// immediately, and releases it synchronously after a synchronizer chain plus a
// programmable hold stretch. Reports completion (`rst_done`) and last cause.
//
// Build option: define RST_SEQUENCER_SW_RST_EN to enable the software reset
// request (`sw_rst_req`). Without it the port exists but is ignored and RUN
// is terminal until `rst` goes low.
//
// state | meaning
// ------+----------------------------------------------------------------
// RESET | `rst` low; output asserted, counter cleared, cause = external
// SYNC  | `rst` released, waiting for the synchronizer chain to fill
// HOLD  | stretch counter running; output still asserted
// RUN   | output deasserted, `rst_done` high

module rst_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 5,
   parameter bit ACTIVE_HIGH = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sw_rst_req,
   output logic       rst_out,
   output logic       rst_done,
   output logic [1:0] rst_cause
);

   localparam logic [1:0] ST_RESET = 2'd0;
   localparam logic [1:0] ST_SYNC  = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_RUN   = 2'd3;

   localparam logic [1:0] CAUSE_EXT = 2'b01;
   localparam logic [1:0] CAUSE_SW  = 2'b10;

   // Counter just wide enough to reach HOLD_CYCLES-1; at least one bit.
   localparam int CW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'((HOLD_CYCLES > 1) ? HOLD_CYCLES - 1 : 0);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

   // Value of rst_out while asserted / deasserted.
   localparam logic LVL_ASSERT   = ACTIVE_HIGH;
   localparam logic LVL_DEASSERT = ~ACTIVE_HIGH;

   logic [SYNC_STAGES-1:0] sync;
   logic [1:0]             state;
   logic [1:0]             state_nxt;
   logic [CW-1:0]          cnt;
   logic [CW-1:0]          cnt_nxt;
   logic [1:0]             cause_nxt;
   logic                   sw_req;
   logic                   hold_last;

`ifdef RST_SEQUENCER_SW_RST_EN
   assign sw_req = sw_rst_req;
`else
   // Request is deliberately dropped; nothing downstream depends on it.
   logic unused_sw_rst_req;
   assign unused_sw_rst_req = sw_rst_req;
   assign sw_req            = 1'b0;
`endif

   // HOLD_CYCLES of 0 or 1 leaves HOLD on the very next edge; a zero-cycle
   // hold still spends one cycle in HOLD after a software request so the
   // output pulse is never zero-width.
   assign hold_last = (HOLD_CYCLES <= 1) ? 1'b1 : (cnt == CNT_LAST);

   // Deassertion synchronizer: cleared by rst, fills with ones afterwards.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], 1'b1};
      end
   end

   // Next-state, counter and cause decode.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cause_nxt = rst_cause;
      case (state)
         ST_RESET: begin
            state_nxt = ST_SYNC;
            cnt_nxt   = '0;
         end
         ST_SYNC: begin
            if (sync[SYNC_STAGES-1]) begin
               state_nxt = (HOLD_CYCLES == 0) ? ST_RUN : ST_HOLD;
               cnt_nxt   = '0;
            end
         end
         ST_HOLD: begin
            if (sw_req) begin
               cnt_nxt   = '0;
               cause_nxt = CAUSE_SW;
            end else if (hold_last) begin
               state_nxt = ST_RUN;
            end else if (cnt != CNT_MAX) begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         ST_RUN: begin
            if (sw_req) begin
               state_nxt = ST_HOLD;
               cnt_nxt   = '0;
               cause_nxt = CAUSE_SW;
            end
         end
         default: begin
            state_nxt = ST_RESET;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State, counter and cause registers; rst forces RESET from anywhere.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_RESET;
         cnt       <= '0;
         rst_cause <= CAUSE_EXT;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         rst_cause <= cause_nxt;
      end
   end

   // Registered outputs, decoded from the next state so release lines up
   // with the RUN transition edge and no input reaches them combinationally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_out  <= LVL_ASSERT;
         rst_done <= 1'b0;
      end else begin
         rst_out  <= (state_nxt == ST_RUN) ? LVL_DEASSERT : LVL_ASSERT;
         rst_done <= (state_nxt == ST_RUN);
      end
   end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: defaults, HOLD_CYCLES=0, ACTIVE_HIGH=0.
module tb_rst_sequencer;

`ifdef RST_SEQUENCER_SW_RST_EN
   localparam bit SW = 1'b1;
`else
   localparam bit SW = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic       rst0 = 1'b0, sw0 = 1'b0, out0, done0;
   logic [1:0] cause0;
   logic       rst1 = 1'b0, sw1 = 1'b0, out1, done1;
   logic [1:0] cause1;
   logic       rst2 = 1'b0, sw2 = 1'b0, out2, done2;
   logic [1:0] cause2;

   rst_sequencer #(.SYNC_STAGES(2), .HOLD_CYCLES(5), .ACTIVE_HIGH(1'b1)) dut0 (
      .clk(clk), .rst(rst0), .sw_rst_req(sw0),
      .rst_out(out0), .rst_done(done0), .rst_cause(cause0));

   rst_sequencer #(.SYNC_STAGES(2), .HOLD_CYCLES(0), .ACTIVE_HIGH(1'b1)) dut1 (
      .clk(clk), .rst(rst1), .sw_rst_req(sw1),
      .rst_out(out1), .rst_done(done1), .rst_cause(cause1));

   rst_sequencer #(.SYNC_STAGES(2), .HOLD_CYCLES(5), .ACTIVE_HIGH(1'b0)) dut2 (
      .clk(clk), .rst(rst2), .sw_rst_req(sw2),
      .rst_out(out2), .rst_done(done2), .rst_cause(cause2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Release dut0 and check the 8-edge deassertion sequence.
   task automatic release_seq0(input string tag);
      rst0 = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         checks++;
         if (out0 !== (e < 8)) begin
            errors++;
            $display("FAIL %s rst_out edge %0d: got %b want %b", tag, e, out0, (e < 8));
         end
         checks++;
         if (done0 !== (e >= 8)) begin
            errors++;
            $display("FAIL %s rst_done edge %0d: got %b want %b", tag, e, done0, (e >= 8));
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks++;
      if (out0 !== 1'b1 || done0 !== 1'b0) begin
         errors++;
         $display("FAIL reset outputs: got out=%b done=%b want out=1 done=0", out0, done0);
      end
      checks++;
      if (cause0 !== 2'b01) begin
         errors++;
         $display("FAIL reset cause: got %b want 01", cause0);
      end
      release_seq0("powerup");
      checks++;
      if (cause0 !== 2'b01) begin
         errors++;
         $display("FAIL powerup cause: got %b want 01", cause0);
      end
   endtask

   task automatic test_async_assert();
      repeat (2) tick();
      #3;
      rst0 = 1'b0;
      #1;
      checks++;
      if (out0 !== 1'b1 || done0 !== 1'b0) begin
         errors++;
         $display("FAIL async assert: got out=%b done=%b want out=1 done=0", out0, done0);
      end
      repeat (2) tick();
      release_seq0("async_release");
   endtask

   task automatic test_sw_reset();
      logic exp;
      repeat (3) tick();
      sw0 = 1'b1;
      for (int e = 0; e <= 5; e++) begin
         tick();
         sw0 = 1'b0;
         exp = SW ? (e < 5) : 1'b0;
         checks++;
         if (out0 !== exp) begin
            errors++;
            $display("FAIL sw_reset rst_out N+%0d: got %b want %b", e, out0, exp);
         end
      end
      checks++;
      if (cause0 !== (SW ? 2'b10 : 2'b01)) begin
         errors++;
         $display("FAIL sw_reset cause: got %b want %b", cause0, (SW ? 2'b10 : 2'b01));
      end
      checks++;
      if (done0 !== 1'b1) begin
         errors++;
         $display("FAIL sw_reset done: got %b want 1", done0);
      end
   endtask

   task automatic test_restart_in_hold();
      logic exp;
      repeat (2) tick();
      sw0 = 1'b1;
      for (int e = 0; e <= 8; e++) begin
         tick();
         sw0 = (e == 2);
         exp = SW ? (e < 8) : 1'b0;
         checks++;
         if (out0 !== exp) begin
            errors++;
            $display("FAIL restart rst_out N+%0d: got %b want %b", e, out0, exp);
         end
      end
      checks++;
      if (done0 !== 1'b1) begin
         errors++;
         $display("FAIL restart done: got %b want 1", done0);
      end
   endtask

   // rst low together with a request: rst wins, request ignored in RESET/SYNC.
   task automatic test_rst_wins();
      repeat (2) tick();
      sw0  = 1'b1;
      rst0 = 1'b0;
      repeat (2) tick();
      checks++;
      if (cause0 !== 2'b01 || out0 !== 1'b1) begin
         errors++;
         $display("FAIL rst_wins: got cause=%b out=%b want cause=01 out=1", cause0, out0);
      end
      rst0 = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (e == 3) sw0 = 1'b0;
         checks++;
         if (out0 !== (e < 8)) begin
            errors++;
            $display("FAIL ignore_sync rst_out edge %0d: got %b want %b", e, out0, (e < 8));
         end
      end
      checks++;
      if (cause0 !== 2'b01) begin
         errors++;
         $display("FAIL ignore_sync cause: got %b want 01", cause0);
      end
   endtask

   task automatic test_glitch();
      // Mid-HOLD glitch on dut0 restarts the full sequence.
      repeat (2) tick();
      rst0 = 1'b0;
      tick();
      rst0 = 1'b1;
      repeat (5) tick();
      rst0 = 1'b0;
      #1;
      checks++;
      if (out0 !== 1'b1 || done0 !== 1'b0) begin
         errors++;
         $display("FAIL hold_glitch: got out=%b done=%b want out=1 done=0", out0, done0);
      end
      tick();
      release_seq0("after_glitch");

      // Short high pulse on the active-low variant never releases it.
      checks++;
      if (out2 !== 1'b0) begin
         errors++;
         $display("FAIL low_pol reset: got %b want 0", out2);
      end
      rst2 = 1'b1;
      tick();
      rst2 = 1'b0;
      for (int e = 0; e < 10; e++) begin
         tick();
         checks++;
         if (out2 !== 1'b0 || done2 !== 1'b0) begin
            errors++;
            $display("FAIL short_pulse edge %0d: got out=%b done=%b want out=0 done=0", e, out2, done2);
         end
      end
      rst2 = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         checks++;
         if (out2 !== (e >= 8) || done2 !== (e >= 8)) begin
            errors++;
            $display("FAIL low_pol release edge %0d: got out=%b done=%b want %b", e, out2, done2, (e >= 8));
         end
      end
   endtask

   task automatic test_hold_zero();
      rst1 = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         tick();
         checks++;
         if (out1 !== (e < 3) || done1 !== (e >= 3)) begin
            errors++;
            $display("FAIL hold0 release edge %0d: got out=%b done=%b want out=%b", e, out1, done1, (e < 3));
         end
      end
      repeat (6) tick();
      sw1 = 1'b1;
      tick();
      sw1 = 1'b0;
      checks++;
      if (out1 !== SW || done1 !== ~SW) begin
         errors++;
         $display("FAIL hold0 pulse: got out=%b done=%b want out=%b", out1, done1, SW);
      end
      for (int e = 1; e <= 3; e++) begin
         tick();
         checks++;
         if (out1 !== 1'b0 || done1 !== 1'b1) begin
            errors++;
            $display("FAIL hold0 after N+%0d: got out=%b done=%b want out=0 done=1", e, out1, done1);
         end
      end
      checks++;
      if (cause1 !== (SW ? 2'b10 : 2'b01)) begin
         errors++;
         $display("FAIL hold0 cause: got %b want %b", cause1, (SW ? 2'b10 : 2'b01));
      end
   endtask

   initial begin
      test_reset();
      test_async_assert();
      test_sw_reset();
      test_restart_in_hold();
      test_rst_wins();
      test_glitch();
      test_hold_zero();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
